seq_alu_core: RTL and testbench
===============================

Name: seq_alu_core

Overview:
Parametrised multi-cycle ALU. It is the next generation of the team's 4-bit combinational TinyTapeout ALU.
- Generalised to WIDTH-bit operands.
- Adds registered valid/ready handshakes, iterative shift-add multiply and restoring divide, status flags, and an accumulator chaining mode.
- Sits between the pin-level input latch and the 7-segment/output mux of the top-level tile.

Parameters:
WIDTH, 8, operand width in bits (>=4); result is 2*WIDTH bits
OPW, 4, opcode width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operation request
in_ready  out  1  core can accept a request
op  in  OPW  opcode
a  in  WIDTH  operand A (unsigned unless op says signed)
b  in  WIDTH  operand B
use_acc  in  1  replace A with accumulator for this request
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  2*WIDTH  operation result
flag_zero  out  1  result == 0
flag_neg  out  1  result[2*WIDTH-1]
flag_carry  out  1  carry (ADD) / borrow (SUB) / bits shifted out nonzero (SHL)
flag_div0  out  1  DIV/MOD with b == 0
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - result, all flags, out_valid and accumulator are cleared to 0.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-operation aborts the operation; no result is produced.
- States and transitions:
  - IDLE -> EXEC on in_valid & in_ready.
  - EXEC -> DONE: after 1 cycle for single-cycle ops; after WIDTH iteration cycles for MUL/DIV/MOD.
  - DONE -> IDLE on out_valid & out_ready.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Capture: op, effective A (acc[WIDTH-1:0] if use_acc else a) and b are registered on accept. Later changes to the inputs have no effect.
- Latency (accept edge to out_valid high): single-cycle ops 2 cycles; MUL/DIV/MOD WIDTH+2 cycles.
- result and flags are held stable while out_valid & !out_ready.
- Throughput: at most one request every latency+1 cycles. There is no overlap and no bypass.
- Accumulator: on the output handshake, acc <= result[WIDTH-1:0].
- Opcodes (A, B are captured values):
  - 0 ADD: result = A+B zero-extended. carry = bit WIDTH.
  - 1 SUB: signed A-B, sign-extended to 2*WIDTH. carry = borrow (unsigned A < B).
  - 2 MUL: unsigned, iterative shift-add, one bit per cycle, full 2*WIDTH product.
  - 3 DIV: unsigned, restoring, one quotient bit per cycle. result = {remainder, quotient}.
  - 4 AND; 5 OR; 6 XOR; 7 NAND; 8 NOR: bitwise on A, B. Upper WIDTH bits are 0.
  - 9 NOT: result = ~{B, A}.
  - 10 MOD: as DIV, but result = remainder zero-extended.
  - 11 SHL: A << B, 2*WIDTH wide. If B >= 2*WIDTH, result = 0 and carry = (A != 0).
  - 12 SHR: logical right shift. If B >= WIDTH, result = 0.
  - 13 ASR: arithmetic right shift of A, sign-extended. If B >= WIDTH, all bits = A[WIDTH-1].
  - 14, 15: result = 0, all flags 0.
- Divide by zero (DIV/MOD, B == 0):
  - Completes as a single-cycle op and sets flag_div0.
  - DIV result = {A zero-extended, all-ones quotient}; MOD result = A.
- flag_zero and flag_neg are computed from the final 2*WIDTH result. Flags not defined for the op are 0.
- in_valid while busy is ignored; the requester must hold it until in_ready.

Test Plan:
- Reset: hold rst_n low 2 cycles during a MUL in progress -> out_valid=0, result=0, acc=0, in_ready=1 on first cycle after release.
- WIDTH=8, ADD a=200 b=100 -> result=0x012C, carry=1, out_valid exactly 2 cycles after accept. Then SUB a=3 b=5 -> result=0xFFFE, neg=1, carry=1.
- MUL a=255 b=255 -> result=0xFE01 after WIDTH+2=10 cycles. DIV a=200 b=7 -> result={0x04,0x1C}. MOD a=200 b=7 -> 0x0004.
- DIV a=9 b=0 -> flag_div0=1, result=0x09FF, 2-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after ADD -> result/flags stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle.
- Accumulator chain: ADD 5+3 (acc=8), then use_acc ADD b=10 -> 0x0012. Then use_acc SHL b=20 -> 0, carry=1. ASR a=0x80 b=9 -> 0xFFFF.

Source files
------------

// File: rtl/seq_alu_core_if.sv
// Request/response bus of the sequential ALU core.
// The master drives requests and out_ready. The slave is the core.
interface seq_alu_core_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [OPW-1:0]     op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               use_acc;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               flag_zero;
    logic               flag_neg;
    logic               flag_carry;
    logic               flag_div0;
    logic               busy;

    modport master (
        output in_valid, op, a, b, use_acc, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_div0, busy
    );

    modport slave (
        input  in_valid, op, a, b, use_acc, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_div0, busy
    );
endinterface

// File: rtl/seq_alu_core.sv
// Multi-cycle WIDTH-bit ALU with a valid/ready handshake, iterative MUL/DIV/MOD and an accumulator.
// EXEC runs a prepare step, then WIDTH iteration steps for MUL/DIV/MOD, then a finalize step.
module seq_alu_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
) (
    input logic          clk,
    input logic          rst_n,
    seq_alu_core_if.slave bus
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned SW = 3 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 2);

    localparam logic [CW-1:0]    STEP_FIN = CW'(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] TWO_W    = WIDTH'(2 * WIDTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(3);
    localparam logic [OPW-1:0] OP_AND  = OPW'(4);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6);
    localparam logic [OPW-1:0] OP_NAND = OPW'(7);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(8);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(9);
    localparam logic [OPW-1:0] OP_MOD  = OPW'(10);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(12);
    localparam logic [OPW-1:0] OP_ASR  = OPW'(13);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state, state_n;
    logic               accept, fin;
    logic [CW-1:0]      step;
    logic [OPW-1:0]     op_q;
    logic [WIDTH-1:0]   a_q, b_q, acc;
    logic [WIDTH-1:0]   hi, lo;
    logic [RW-1:0]      res_q, res_fin, single_res;
    logic               carry_q, div0_q, single_carry;
    logic               is_mul, is_div, is_mod, is_multi, is_div0, reserved;

    logic [WIDTH:0]          add_s;
    logic signed [WIDTH:0]   sub_d;
    logic [SW-1:0]           shl_t;
    logic signed [WIDTH-1:0] asr_v;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          div_sh;
    logic                    div_ge;
    logic [WIDTH-1:0]        div_diff;

    // State register; handshake outputs are registered copies of the next-state decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_n;
            bus.in_ready  <= (state_n == IDLE);
            bus.out_valid <= (state_n == DONE);
            bus.busy      <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: if (bus.in_valid) begin
                accept  = 1'b1;
                state_n = EXEC;
            end
            EXEC: if (step == STEP_FIN) begin
                fin     = 1'b1;
                state_n = DONE;
            end
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        is_mul   = (op_q == OP_MUL);
        is_div   = (op_q == OP_DIV);
        is_mod   = (op_q == OP_MOD);
        is_div0  = (is_div || is_mod) && (b_q == '0);
        is_multi = is_mul || ((is_div || is_mod) && (b_q != '0));
        reserved = (op_q > OP_ASR);
    end

    // Single-cycle results, also the divide-by-zero fallbacks for DIV/MOD
    always_comb begin
        single_res   = '0;
        single_carry = 1'b0;
        add_s = {1'b0, a_q} + {1'b0, b_q};
        sub_d = $signed({a_q[WIDTH-1], a_q}) - $signed({b_q[WIDTH-1], b_q});
        shl_t = SW'(a_q) << b_q;
        asr_v = $signed(a_q) >>> b_q;
        case (op_q)
            OP_ADD: begin
                single_res   = {{(WIDTH-1){1'b0}}, add_s};
                single_carry = add_s[WIDTH];
            end
            OP_SUB: begin
                single_res   = {{(WIDTH-1){sub_d[WIDTH]}}, sub_d};
                single_carry = (a_q < b_q);
            end
            OP_DIV:  single_res = {a_q, {WIDTH{1'b1}}};
            OP_MOD:  single_res = {{WIDTH{1'b0}}, a_q};
            OP_AND:  single_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:   single_res = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR:  single_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_NAND: single_res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
            OP_NOR:  single_res = {{WIDTH{1'b0}}, ~(a_q | b_q)};
            OP_NOT:  single_res = ~{b_q, a_q};
            OP_SHL: begin
                if (b_q >= TWO_W) begin
                    single_res   = '0;
                    single_carry = (a_q != '0);
                end else begin
                    single_res   = shl_t[RW-1:0];
                    single_carry = (shl_t[SW-1:RW] != '0);
                end
            end
            OP_SHR: single_res = (b_q >= W_LIM) ? '0 : {{WIDTH{1'b0}}, a_q >> b_q};
            OP_ASR: single_res = (b_q >= W_LIM) ? {RW{a_q[WIDTH-1]}}
                                                : {{WIDTH{asr_v[WIDTH-1]}}, asr_v};
            default: ;
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide on {hi, lo}
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
        div_sh   = {hi, lo[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_diff = div_sh[WIDTH-1:0] - b_q;
    end

    always_comb begin
        res_fin = res_q;
        if (!div0_q) begin
            if (is_mul || is_div) res_fin = {hi, lo};
            else if (is_mod)      res_fin = {{WIDTH{1'b0}}, hi};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step           <= '0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            acc            <= '0;
            hi             <= '0;
            lo             <= '0;
            res_q          <= '0;
            carry_q        <= 1'b0;
            div0_q         <= 1'b0;
            bus.result     <= '0;
            bus.flag_zero  <= 1'b0;
            bus.flag_neg   <= 1'b0;
            bus.flag_carry <= 1'b0;
            bus.flag_div0  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.use_acc ? acc : bus.a;
                b_q  <= bus.b;
                step <= '0;
            end
            if (state == EXEC) begin
                if (step == '0) begin
                    res_q   <= single_res;
                    carry_q <= single_carry;
                    div0_q  <= is_div0;
                    hi      <= '0;
                    lo      <= (is_div || is_mod) ? a_q : b_q;
                    step    <= is_multi ? CW'(1) : STEP_FIN;
                end else if (!fin) begin
                    if (is_mul) begin
                        hi <= mul_sum[WIDTH:1];
                        lo <= {mul_sum[0], lo[WIDTH-1:1]};
                    end else begin
                        hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], div_ge};
                    end
                    step <= step + CW'(1);
                end else begin
                    bus.result     <= res_fin;
                    bus.flag_zero  <= (res_fin == '0) && !reserved;
                    bus.flag_neg   <= res_fin[RW-1];
                    bus.flag_carry <= carry_q;
                    bus.flag_div0  <= div0_q;
                end
            end
            if (state == DONE && bus.out_ready) acc <= bus.result[WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core at WIDTH=8: latency, results, flags, backpressure,
// mid-operation reset and accumulator chaining against hand-computed values.
module tb_seq_alu_core;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned OPW   = 4;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, AND_ = 4'd4,
                           OR_ = 4'd5, XOR_ = 4'd6, NAND_ = 4'd7, NOR_ = 4'd8, NOT_ = 4'd9,
                           MOD = 4'd10, SHL = 4'd11, SHR = 4'd12, ASR = 4'd13, RSV = 4'd14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_alu_core_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    seq_alu_core #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({bus.flag_zero, bus.flag_neg, bus.flag_carry, bus.flag_div0});
    endfunction

    // Issue one request, scramble the inputs after accept, and count edges until out_valid.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input string tag, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.use_acc  = ua;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 4'hF;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.use_acc  = ~ua;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, input logic [15:0] exp_res, input logic [3:0] exp_flg,
                       input int exp_lat, input string tag);
        int lat;
        send(op, a, b, ua, tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(bus.result), 32'(exp_res));
        check({tag, "_flg"}, flags(), 32'(exp_flg));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.use_acc   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Flags are {zero, neg, carry, div0}
        run(ADD, 8'd1, 8'd2, 1'b0, 16'h0003, 4'b0000, 2, "add_1_2");

        // Reset in the middle of a MUL aborts it and clears the accumulator
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = MUL; bus.a = 8'd200; bus.b = 8'd50;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_flags", flags(), 32'd0);
        repeat (12) @(negedge clk);
        check("mid_rst_no_result", 32'(bus.out_valid), 32'd0);
        check("mid_rst_idle", 32'(bus.busy), 32'd0);
        run(ADD, 8'hAA, 8'd0, 1'b1, 16'h0000, 4'b1000, 2, "acc_after_rst");

        run(ADD, 8'd200, 8'd100, 1'b0, 16'h012C, 4'b0010, 2, "add_200_100");
        run(SUB, 8'd3, 8'd5, 1'b0, 16'hFFFE, 4'b0110, 2, "sub_3_5");
        run(SUB, 8'd5, 8'd3, 1'b0, 16'h0002, 4'b0000, 2, "sub_5_3");
        run(MUL, 8'd255, 8'd255, 1'b0, 16'hFE01, 4'b0100, 10, "mul_255_255");
        run(MUL, 8'd13, 8'd11, 1'b0, 16'h008F, 4'b0000, 10, "mul_13_11");
        run(MUL, 8'd0, 8'd77, 1'b0, 16'h0000, 4'b1000, 10, "mul_0_77");
        run(DIV, 8'd200, 8'd7, 1'b0, 16'h041C, 4'b0000, 10, "div_200_7");
        run(DIV, 8'd255, 8'd16, 1'b0, 16'h0F0F, 4'b0000, 10, "div_255_16");
        run(MOD, 8'd200, 8'd7, 1'b0, 16'h0004, 4'b0000, 10, "mod_200_7");
        run(DIV, 8'd9, 8'd0, 1'b0, 16'h09FF, 4'b0001, 2, "div_9_0");
        run(MOD, 8'd9, 8'd0, 1'b0, 16'h0009, 4'b0001, 2, "mod_9_0");
        run(AND_, 8'hF0, 8'h3C, 1'b0, 16'h0030, 4'b0000, 2, "and");
        run(OR_, 8'h0F, 8'h30, 1'b0, 16'h003F, 4'b0000, 2, "or");
        run(XOR_, 8'hFF, 8'hFF, 1'b0, 16'h0000, 4'b1000, 2, "xor");
        run(NAND_, 8'hFF, 8'h0F, 1'b0, 16'h00F0, 4'b0000, 2, "nand");
        run(NOR_, 8'h0F, 8'hF0, 1'b0, 16'h0000, 4'b1000, 2, "nor");
        run(NOT_, 8'h0F, 8'hF0, 1'b0, 16'h0FF0, 4'b0000, 2, "not");
        run(SHL, 8'h81, 8'd4, 1'b0, 16'h0810, 4'b0000, 2, "shl_4");
        run(SHL, 8'h81, 8'd9, 1'b0, 16'h0200, 4'b0010, 2, "shl_9");
        run(SHR, 8'hF0, 8'd4, 1'b0, 16'h000F, 4'b0000, 2, "shr_4");
        run(SHR, 8'h80, 8'd9, 1'b0, 16'h0000, 4'b1000, 2, "shr_9");
        run(ASR, 8'h90, 8'd2, 1'b0, 16'hFFE4, 4'b0100, 2, "asr_2");
        run(RSV, 8'd0, 8'd0, 1'b0, 16'h0000, 4'b0000, 2, "rsv_14");

        // Backpressure: result held, new requests ignored while waiting on out_ready
        send(ADD, 8'd10, 8'd20, 1'b0, "bp", lat);
        check("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.op = SUB; bus.a = 8'(i + 40); bus.b = 8'd1;
            @(negedge clk);
            check("bp_hold_res", 32'(bus.result), 32'h001E);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_flags", flags(), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("bp_no_queued_req", 32'(bus.busy), 32'd0);

        // Accumulator chaining
        run(ADD, 8'd5, 8'd3, 1'b0, 16'h0008, 4'b0000, 2, "chain_add");
        run(ADD, 8'hAA, 8'd10, 1'b1, 16'h0012, 4'b0000, 2, "chain_acc_add");
        run(SHL, 8'h00, 8'd20, 1'b1, 16'h0000, 4'b1010, 2, "chain_acc_shl");
        run(ASR, 8'h80, 8'd9, 1'b0, 16'hFFFF, 4'b0100, 2, "asr_9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
